// File: rtl/decoder_pkg.sv
// Shared widths, FSM encoding and the fixed XOR key table for memory_decoder.
package decoder_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Element 0 sits in the least significant byte.
  localparam logic [DEPTH-1:0][DATA_W-1:0] KEY_TABLE = {
    8'hFF, 8'hF0, 8'h0F, 8'hCC, 8'h33, 8'hAA, 8'h55, 8'h00
  };

  function automatic logic [DATA_W-1:0] key_of(input logic [IDX_W-1:0] addr);
    return KEY_TABLE[addr];
  endfunction

endpackage

// File: rtl/key_rom.sv
// Combinational key lookup: 3-bit storage address to its 8-bit XOR key.
module key_rom
  import decoder_pkg::*;
(
  input  logic [IDX_W-1:0]  addr,
  output logic [DATA_W-1:0] key
);

  assign key = key_of(addr);

endmodule

// File: rtl/memory_decoder.sv
// 8x8 encoded store with a handshaked burst decoder (stored XOR key[index]).
// Optional burst checksum output when DECODER_CHECKSUM_EN is defined.
module memory_decoder
  import decoder_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_BYTE = 8'h00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_index,
  input  logic [CNT_W-1:0]  count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
`ifdef DECODER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done
);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   rem;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  key;

  key_rom u_key_rom (
    .addr (idx),
    .key  (key)
  );

  // Storage writes are independent of the FSM; a write landing on the same
  // edge as FETCH is seen only by later fetches (non-blocking update).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      idx       <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DECODER_CHECKSUM_EN
      checksum  <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_BYTE;
    end else begin
      if (wr_en) mem[wr_index] <= wr_data;
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            idx <= first_index;
            rem <= count;
`ifdef DECODER_CHECKSUM_EN
            checksum <= '0;
`endif
            if (count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FETCH;
              busy  <= 1'b1;
            end
          end
        end

        ST_FETCH: begin
          out_index <= idx;
          out_data  <= mem[idx] ^ key;
          out_valid <= 1'b1;
          state     <= ST_PRESENT;
        end

        // out_data is a registered copy, so writes to the presented index
        // cannot disturb it while the consumer stalls.
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            idx       <= idx + 3'd1;
            rem       <= rem - 4'd1;
`ifdef DECODER_CHECKSUM_EN
            checksum  <= checksum ^ out_data;
`endif
            if (rem == 4'd1) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_decoder.sv
// Directed self-checking bench for memory_decoder.
module tb_memory_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       wr_en;
  logic [2:0] wr_index;
  logic [7:0] wr_data;
  logic       start;
  logic [2:0] first_index;
  logic [3:0] count;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_index;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
`ifdef DECODER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  memory_decoder #(.INIT_BYTE(8'h00)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .wr_en       (wr_en),
    .wr_index    (wr_index),
    .wr_data     (wr_data),
    .start       (start),
    .first_index (first_index),
    .count       (count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_data    (out_data),
    .busy        (busy),
`ifdef DECODER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .done        (done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0] keys [8] = '{8'h00, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0F, 8'hF0, 8'hFF};
  logic [7:0] wdat [8] = '{8'hAA, 8'hFF, 8'h00, 8'h99, 8'h66, 8'hA5, 8'h5A, 8'h55};
  logic [7:0] mdl  [8];

  logic [2:0] obs_idx [$];
  logic [7:0] obs_data [$];
  bit         obs_done;
  int         obs_cycles;
  logic [7:0] obs_csum;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_byte(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_index = a; wr_data = d;
    step();
    wr_en = 1'b0;
    mdl[a] = d;
  endtask

  // Drives a burst with out_ready=1 and records what the DUT presents.
  task automatic run_burst(input logic [2:0] fi, input logic [3:0] cnt);
    obs_idx.delete(); obs_data.delete();
    obs_done = 0; obs_cycles = 0; obs_csum = 8'h00;
    out_ready = 1'b1; start = 1'b1; first_index = fi; count = cnt;
    step();
    start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      obs_cycles = c + 1;
      if (out_valid) begin
        obs_idx.push_back(out_index);
        obs_data.push_back(out_data);
      end
      if (done) begin
        obs_done = 1;
`ifdef DECODER_CHECKSUM_EN
        obs_csum = checksum;
`endif
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, done} !== 3'b000 || out_index !== 3'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b idx=%0d data=%h, required all zero",
               out_valid, busy, done, out_index, out_data);
    end
    step(); step();
    RST = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
  endtask

  task automatic test_empty_storage();
    run_burst(3'd0, 4'd8);
    checks++;
    if (!obs_done || obs_idx.size() != 8) begin
      errors++;
      $display("FAIL empty_burst_len: done=%0d beats=%0d, required done=1 beats=8", obs_done, obs_idx.size());
    end
    for (int i = 0; i < obs_idx.size(); i++) begin
      checks++;
      if (obs_idx[i] !== 3'(i) || obs_data[i] !== (8'h00 ^ keys[i])) begin
        errors++;
        $display("FAIL empty_beat%0d: idx=%0d data=%h, required idx=%0d data=%h",
                 i, obs_idx[i], obs_data[i], i, 8'h00 ^ keys[i]);
      end
    end
  endtask

  task automatic test_decode_full();
    for (int i = 0; i < 8; i++) write_byte(3'(i), wdat[i]);
    run_burst(3'd0, 4'd8);
    checks++;
    if (!obs_done || obs_idx.size() != 8) begin
      errors++;
      $display("FAIL full_burst_len: done=%0d beats=%0d, required done=1 beats=8", obs_done, obs_idx.size());
    end
    for (int i = 0; i < obs_idx.size(); i++) begin
      checks++;
      if (obs_idx[i] !== 3'(i) || obs_data[i] !== 8'hAA) begin
        errors++;
        $display("FAIL full_beat%0d: idx=%0d data=%h, required idx=%0d data=aa", i, obs_idx[i], obs_data[i], i);
      end
    end
`ifdef DECODER_CHECKSUM_EN
    checks++;
    if (obs_csum !== 8'h00) begin
      errors++;
      $display("FAIL full_checksum: got %h, required 00", obs_csum);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [2:0] exp_idx [3] = '{3'd6, 3'd7, 3'd0};
    run_burst(3'd6, 4'd3);
    checks++;
    if (!obs_done || obs_idx.size() != 3) begin
      errors++;
      $display("FAIL wrap_len: done=%0d beats=%0d, required done=1 beats=3", obs_done, obs_idx.size());
    end
    for (int i = 0; i < obs_idx.size() && i < 3; i++) begin
      checks++;
      if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== 8'hAA) begin
        errors++;
        $display("FAIL wrap_beat%0d: idx=%0d data=%h, required idx=%0d data=aa", i, obs_idx[i], obs_data[i], exp_idx[i]);
      end
    end
`ifdef DECODER_CHECKSUM_EN
    checks++;
    if (obs_csum !== 8'hAA) begin
      errors++;
      $display("FAIL wrap_checksum: got %h, required aa", obs_csum);
    end
`endif
  endtask

  task automatic test_stall();
    int beats = 0;
    bit seen_done = 0;
    out_ready = 1'b0; start = 1'b1; first_index = 3'd2; count = 4'd2;
    step();
    start = 1'b0;
    for (int c = 0; c < 10 && !out_valid; c++) step();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'd2 || out_data !== 8'hAA) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%b idx=%0d data=%h, required valid=1 idx=2 data=aa",
                 k, out_valid, out_index, out_data);
      end
      if (k == 0) begin
        start = 1'b1; first_index = 3'd7; count = 4'd0;
        wr_en = 1'b1; wr_index = 3'd2; wr_data = 8'h12;
      end
      step();
      start = 1'b0; wr_en = 1'b0;
    end
    mdl[2] = 8'h12;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        checks++;
        if (out_index !== 3'(2 + beats) || out_data !== 8'hAA) begin
          errors++;
          $display("FAIL stall_beat%0d: idx=%0d data=%h, required idx=%0d data=aa", beats, out_index, out_data, 2 + beats);
        end
        beats++;
      end
      if (done) begin
        seen_done = 1;
        break;
      end
      step();
    end
    checks++;
    if (!seen_done || beats != 2) begin
      errors++;
      $display("FAIL stall_burst_len: done=%0d beats=%0d, required done=1 beats=2", seen_done, beats);
    end
    step();
    run_burst(3'd2, 4'd1);
    checks++;
    if (obs_idx.size() != 1 || obs_data[0] !== (8'h12 ^ 8'hAA)) begin
      errors++;
      $display("FAIL stall_new_value: beats=%0d data=%h, required beats=1 data=b8",
               obs_idx.size(), obs_data.size() > 0 ? obs_data[0] : 8'hxx);
    end
  endtask

  task automatic test_zero_count();
    run_burst(3'd5, 4'd0);
    checks++;
    if (!obs_done || obs_cycles > 2 || obs_idx.size() != 0) begin
      errors++;
      $display("FAIL zero_count: done=%0d cycles=%0d beats=%0d, required done=1 cycles<=2 beats=0",
               obs_done, obs_cycles, obs_idx.size());
    end
`ifdef DECODER_CHECKSUM_EN
    checks++;
    if (obs_csum !== 8'h00) begin
      errors++;
      $display("FAIL zero_checksum: got %h, required 00", obs_csum);
    end
`endif
  endtask

  task automatic test_fetch_collision();
    out_ready = 1'b0; start = 1'b1; first_index = 3'd4; count = 4'd1;
    step();
    start = 1'b0;
    wr_en = 1'b1; wr_index = 3'd4; wr_data = 8'h00;
    step();
    wr_en = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== (8'h66 ^ 8'hCC)) begin
      errors++;
      $display("FAIL collision_old: valid=%b data=%h, required valid=1 data=aa", out_valid, out_data);
    end
    mdl[4] = 8'h00;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && !done; c++) step();
    step();
    run_burst(3'd4, 4'd1);
    checks++;
    if (obs_idx.size() != 1 || obs_data[0] !== 8'hCC) begin
      errors++;
      $display("FAIL collision_new: beats=%0d data=%h, required beats=1 data=cc",
               obs_idx.size(), obs_data.size() > 0 ? obs_data[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_midburst();
    bit saw_done = 0;
    out_ready = 1'b1; start = 1'b1; first_index = 3'd0; count = 4'd8;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, done} !== 3'b000 || out_index !== 3'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL midburst_reset: valid=%b busy=%b done=%b idx=%0d data=%h, required all zero",
               out_valid, busy, done, out_index, out_data);
    end
    step();
    RST = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    for (int c = 0; c < 6; c++) begin
      if (done || busy || out_valid) saw_done = 1;
      step();
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_quiet: activity seen after aborted burst, required none");
    end
    run_burst(3'd0, 4'd8);
    checks++;
    if (obs_idx.size() != 8) begin
      errors++;
      $display("FAIL post_reset_len: beats=%0d, required 8", obs_idx.size());
    end
    for (int i = 0; i < obs_idx.size(); i++) begin
      checks++;
      if (obs_data[i] !== (mdl[i] ^ keys[i])) begin
        errors++;
        $display("FAIL post_reset_beat%0d: data=%h, required %h", i, obs_data[i], mdl[i] ^ keys[i]);
      end
    end
  endtask

  initial begin
    wr_en = 1'b0; wr_index = 3'd0; wr_data = 8'h00;
    start = 1'b0; first_index = 3'd0; count = 4'd0; out_ready = 1'b1;
    test_reset();
    test_empty_storage();
    test_decode_full();
    test_wrap();
    test_stall();
    test_zero_count();
    test_fetch_collision();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
